// File: rtl/ibex_fetch_align_buffer_pkg.sv
// Types shared by the fetch align buffer and its word FIFO.
// Classifies where the head instruction sits relative to the buffered words.
package ibex_fetch_align_buffer_pkg;

    typedef enum logic [1:0] {
        ALIGN_LO_COMP,
        ALIGN_LO_FULL,
        ALIGN_HI_COMP,
        ALIGN_STRADDLE
    } align_case_e;

    localparam logic [1:0] UNCOMPRESSED_OPC = 2'b11;

endpackage

// File: rtl/ibex_fetch_word_fifo.sv
// Word FIFO for the fetch align buffer: flushable, exposes the head and head+1
// entries plus an occupancy count.
module ibex_fetch_word_fifo
    import ibex_fetch_align_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [31:0]      wdata_i,
    input  logic             pop_i,
    output logic [31:0]      head_o,
    output logic [31:0]      next_o,
    output logic [CNT_W-1:0] count_o
);

    logic [31:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_next;
    logic [CNT_W-1:0] count_q;

    assign rd_ptr_next = rd_ptr_q + 1'b1;

    // Storage is cleared only by reset so the instruction output reads zero
    // afterwards; a flush just empties the queue.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_next;
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign next_o  = mem_q[rd_ptr_next];
    assign count_o = count_q;

endmodule

// File: rtl/ibex_fetch_align_buffer.sv
// Fetch align buffer: buffers fetched words and hands out one aligned 16/32-bit
// instruction per handshake, including instructions straddling two words.
module ibex_fetch_align_buffer
    import ibex_fetch_align_buffer_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0080
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] in_rdata_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_rdata_o,
    output logic [31:0] out_pc_o,
    output logic        out_compressed_o
);

    localparam int unsigned      CNT_W     = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] TWO_CNT   = CNT_W'(2);

    function automatic logic is_compressed(input logic [1:0] opc);
        return opc != UNCOMPRESSED_OPC;
    endfunction

    logic [31:0]      pc_q;
    logic [31:0]      head_word;
    logic [31:0]      next_word;
    logic [CNT_W-1:0] count;
    align_case_e      align_case;
    logic [31:0]      instr;
    logic             instr_compressed;
    logic             need_two;
    logic             pop_head;
    logic             have_instr;
    logic             push;
    logic             consume;
    logic             pop;

    assign in_ready_o = ~rst_i & ~redirect_i & (count < DEPTH_CNT);
    assign push       = in_valid_i & in_ready_o;
    assign consume    = out_valid_o & out_ready_i;
    assign pop        = consume & pop_head;

    ibex_fetch_word_fifo #(
        .DEPTH (DEPTH)
    ) u_word_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (redirect_i),
        .push_i  (push),
        .wdata_i (in_rdata_i),
        .pop_i   (pop),
        .head_o  (head_word),
        .next_o  (next_word),
        .count_o (count)
    );

    always_comb begin
        align_case = ALIGN_LO_COMP;
        if (!pc_q[1]) begin
            align_case = is_compressed(head_word[1:0]) ? ALIGN_LO_COMP : ALIGN_LO_FULL;
        end else begin
            align_case = is_compressed(head_word[17:16]) ? ALIGN_HI_COMP : ALIGN_STRADDLE;
        end
    end

    // Only a low-half compressed instruction leaves part of the head word unused.
    always_comb begin
        instr            = '0;
        instr_compressed = 1'b0;
        need_two         = 1'b0;
        pop_head         = 1'b1;
        case (align_case)
            ALIGN_LO_COMP: begin
                instr            = {16'b0, head_word[15:0]};
                instr_compressed = 1'b1;
                pop_head         = 1'b0;
            end
            ALIGN_LO_FULL: begin
                instr = head_word;
            end
            ALIGN_HI_COMP: begin
                instr            = {16'b0, head_word[31:16]};
                instr_compressed = 1'b1;
            end
            ALIGN_STRADDLE: begin
                instr    = {next_word[15:0], head_word[31:16]};
                need_two = 1'b1;
            end
            default: begin
                instr = '0;
            end
        endcase
    end

    assign have_instr = need_two ? (count >= TWO_CNT) : (count != '0);

    assign out_valid_o      = ~rst_i & ~redirect_i & have_instr;
    assign out_rdata_o      = instr;
    assign out_pc_o         = pc_q;
    assign out_compressed_o = instr_compressed & (count != '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q <= BOOT_ADDR;
        end else if (redirect_i) begin
            pc_q <= {redirect_pc_i[31:1], 1'b0};
        end else if (consume) begin
            pc_q <= pc_q + (instr_compressed ? 32'd2 : 32'd4);
        end
    end

endmodule

// File: tb/tb_ibex_fetch_align_buffer.sv
// Self-checking bench for ibex_fetch_align_buffer: a queue of expected
// instructions is checked against every consumed output.
module tb_ibex_fetch_align_buffer;

    localparam int unsigned DEPTH     = 4;
    localparam logic [31:0] BOOT_ADDR = 32'h0000_0080;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] in_rdata_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_rdata_o;
    logic [31:0] out_pc_o;
    logic        out_compressed_o;

    typedef struct packed {
        logic [31:0] rdata;
        logic [31:0] pc;
        logic        comp;
    } exp_t;

    exp_t        exp_q[$];
    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] words [5];

    ibex_fetch_align_buffer #(
        .DEPTH     (DEPTH),
        .BOOT_ADDR (BOOT_ADDR)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i),
        .in_valid_i       (in_valid_i),
        .in_ready_o       (in_ready_o),
        .in_rdata_i       (in_rdata_i),
        .out_valid_o      (out_valid_o),
        .out_ready_i      (out_ready_i),
        .out_rdata_o      (out_rdata_o),
        .out_pc_o         (out_pc_o),
        .out_compressed_o (out_compressed_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic expectInstr(input logic [31:0] rdata, input logic [31:0] pc, input logic comp);
        exp_t e;
        e.rdata = rdata;
        e.pc    = pc;
        e.comp  = comp;
        exp_q.push_back(e);
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled mid-cycle.
    task automatic applyStimulus(input logic v, input logic [31:0] d, input logic rdy,
                                 input logic redir = 1'b0, input logic [31:0] rpc = 32'h0);
        in_valid_i    = v;
        in_rdata_i    = d;
        out_ready_i   = rdy;
        redirect_i    = redir;
        redirect_pc_i = rpc;
        #1;
    endtask

    task automatic step();
        exp_t e;
        #2;
        if (out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_instr", {31'b0, out_valid_o}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("sb_rdata", out_rdata_o, e.rdata);
                checkOutput("sb_pc", out_pc_o, e.pc);
                checkOutput("sb_comp", {31'b0, out_compressed_o}, {31'b0, e.comp});
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic doReset();
        rst_i = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0);
        step();
        rst_i = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int k = 0; k < 5; k++) begin
            words[k] = 32'h0000_0013 | (32'(k + 1) << 7);
        end
        rst_i = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0);
        @(posedge clk_i);
        #1;

        // Reset values
        step();
        checkOutput("rst_valid", {31'b0, out_valid_o}, 32'd0);
        checkOutput("rst_rdata", out_rdata_o, 32'h0);
        checkOutput("rst_pc", out_pc_o, BOOT_ADDR);
        checkOutput("rst_comp", {31'b0, out_compressed_o}, 32'd0);
        checkOutput("rst_in_ready", {31'b0, in_ready_o}, 32'd0);
        rst_i = 1'b0;
        #1;
        checkOutput("rst_release_ready", {31'b0, in_ready_o}, 32'd1);

        // Single uncompressed word
        applyStimulus(1'b1, 32'h00B5_0533, 1'b0);
        expectInstr(32'h00B5_0533, 32'h80, 1'b0);
        step();
        checkOutput("single_valid", {31'b0, out_valid_o}, 32'd1);
        checkOutput("single_rdata", out_rdata_o, 32'h00B5_0533);
        checkOutput("single_pc", out_pc_o, 32'h80);
        checkOutput("single_comp", {31'b0, out_compressed_o}, 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b1);
        step();
        checkOutput("single_empty", {31'b0, out_valid_o}, 32'd0);
        checkOutput("single_pc_next", out_pc_o, 32'h84);

        // Two compressed instructions in one word
        doReset();
        expectInstr(32'h0000_4501, 32'h80, 1'b1);
        expectInstr(32'h0000_4501, 32'h82, 1'b1);
        applyStimulus(1'b1, 32'h4501_4501, 1'b1);
        step();
        applyStimulus(1'b0, 32'h0, 1'b1);
        step();
        step();
        step();
        checkOutput("cc_empty", {31'b0, out_valid_o}, 32'd0);
        checkOutput("cc_pc", out_pc_o, 32'h84);
        checkOutput("cc_sb_drained", exp_q.size(), 32'd0);

        // Instruction straddling a word boundary
        doReset();
        expectInstr(32'h0000_4501, 32'h80, 1'b1);
        applyStimulus(1'b1, 32'h0533_4501, 1'b1);
        step();
        applyStimulus(1'b0, 32'h0, 1'b1);
        step();
        checkOutput("straddle_wait_valid", {31'b0, out_valid_o}, 32'd0);
        checkOutput("straddle_wait_pc", out_pc_o, 32'h82);
        expectInstr(32'h00B5_0533, 32'h82, 1'b0);
        applyStimulus(1'b1, 32'h0000_00B5, 1'b1);
        step();
        applyStimulus(1'b0, 32'h0, 1'b1);
        step();
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("straddle_tail_pc", out_pc_o, 32'h86);
        checkOutput("straddle_tail_valid", {31'b0, out_valid_o}, 32'd1);
        checkOutput("straddle_tail_comp", {31'b0, out_compressed_o}, 32'd1);
        checkOutput("straddle_sb_drained", exp_q.size(), 32'd0);

        // Full buffer back-pressure
        doReset();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, words[k], 1'b0);
            checkOutput($sformatf("full_ready_%0d", k), {31'b0, in_ready_o}, 32'd1);
            expectInstr(words[k], 32'h80 + 32'(4 * k), 1'b0);
            step();
        end
        applyStimulus(1'b1, words[4], 1'b0);
        checkOutput("full_stall", {31'b0, in_ready_o}, 32'd0);
        step();
        applyStimulus(1'b1, words[4], 1'b1);
        checkOutput("full_stall_consume", {31'b0, in_ready_o}, 32'd0);
        step();
        applyStimulus(1'b1, words[4], 1'b0);
        checkOutput("full_reopen", {31'b0, in_ready_o}, 32'd1);
        expectInstr(words[4], 32'h90, 1'b0);
        step();
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("full_again", {31'b0, in_ready_o}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 32'h0, 1'b1);
            step();
        end
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("full_drained_valid", {31'b0, out_valid_o}, 32'd0);
        checkOutput("full_sb_drained", exp_q.size(), 32'd0);

        // Redirect mid-stream drops buffered and concurrent words
        doReset();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, words[k], 1'b0);
            step();
        end
        applyStimulus(1'b1, words[3], 1'b1, 1'b1, 32'h0000_1003);
        checkOutput("redir_valid_gate", {31'b0, out_valid_o}, 32'd0);
        checkOutput("redir_ready_gate", {31'b0, in_ready_o}, 32'd0);
        step();
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("redir_valid", {31'b0, out_valid_o}, 32'd0);
        checkOutput("redir_pc", out_pc_o, 32'h0000_1002);
        checkOutput("redir_ready", {31'b0, in_ready_o}, 32'd1);
        expectInstr(32'h0000_4501, 32'h0000_1002, 1'b1);
        applyStimulus(1'b1, 32'h4501_0000, 1'b0);
        step();
        checkOutput("redir_out_valid", {31'b0, out_valid_o}, 32'd1);
        checkOutput("redir_out_rdata", out_rdata_o, 32'h0000_4501);
        applyStimulus(1'b0, 32'h0, 1'b1);
        step();
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("redir_after_valid", {31'b0, out_valid_o}, 32'd0);
        checkOutput("redir_after_pc", out_pc_o, 32'h0000_1004);
        checkOutput("redir_sb_drained", exp_q.size(), 32'd0);

        // Reset while full
        doReset();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, words[k], 1'b0);
            step();
        end
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("rfull_valid", {31'b0, out_valid_o}, 32'd1);
        checkOutput("rfull_ready", {31'b0, in_ready_o}, 32'd0);
        rst_i = 1'b1;
        #1;
        checkOutput("rfull_rst_ready", {31'b0, in_ready_o}, 32'd0);
        step();
        checkOutput("rfull_post_valid", {31'b0, out_valid_o}, 32'd0);
        checkOutput("rfull_post_pc", out_pc_o, BOOT_ADDR);
        checkOutput("rfull_post_rdata", out_rdata_o, 32'h0);
        checkOutput("rfull_post_comp", {31'b0, out_compressed_o}, 32'd0);
        rst_i = 1'b0;
        #1;
        checkOutput("rfull_post_ready", {31'b0, in_ready_o}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ibex_fetch_align_buffer.md
# ibex_fetch_align_buffer

Upstream feeder of the static branch predictor: buffers 32-bit instruction-memory words in a small FIFO and extracts one aligned instruction per handshake. It handles mixed 16/32-bit (compressed/uncompressed) streams, including 32-bit instructions straddling a word boundary. It presents instruction, PC and valid to the predictor and decoder. A redirect (predicted-taken branch, jump or exception) flushes the buffer and restarts at a new halfword-aligned PC.

## Interface
- `DEPTH`, default 4: FIFO depth in 32-bit words; power of two, at least 2.
- `BOOT_ADDR`, default 32'h0000_0080: PC after reset; halfword aligned.

- `clk_i`  in  1  clock
- `rst_i`  in  1  reset, synchronous, active-high
- `redirect_i`  in  1  flush buffer, restart at `redirect_pc_i`
- `redirect_pc_i`  in  32  new PC; bit 0 ignored
- `in_valid_i`  in  1  fetched word valid
- `in_ready_o`  out  1  buffer accepts word
- `in_rdata_i`  in  32  fetched word
- `out_valid_o`  out  1  complete instruction available
- `out_ready_i`  in  1  consumer takes instruction
- `out_rdata_o`  out  32  instruction; compressed ones zero-extended to 32 bits
- `out_pc_o`  out  32  PC of `out_rdata_o`
- `out_compressed_o`  out  1  instruction is 16-bit

## Operation
- **State:**
  - word FIFO (storage, read pointer, write pointer, count of width $clog2(DEPTH+1));
  - `pc_q`, the PC of the head instruction.
- **Input words:** words arrive in order. The first word after reset or redirect is the word containing `pc_q`, i.e. address `{pc_q[31:2],2'b00}`.
- **Push:** occurs when `in_valid_i & in_ready_o`.
- **`in_ready_o`:** `~rst_i & ~redirect_i & (count < DEPTH)`. It depends on registered state only and never on `out_ready_i`.
- **Alignment:** H is the head word, N the next word, and the halfword is selected by `pc_q[1]`.
  - `pc_q[1]=0`, `H[1:0]!=2'b11`: compressed, `{16'b0,H[15:0]}`; needs count>=1.
  - `pc_q[1]=0`, `H[1:0]==2'b11`: full word H; needs count>=1.
  - `pc_q[1]=1`, `H[17:16]!=2'b11`: compressed, `{16'b0,H[31:16]}`; needs count>=1.
  - `pc_q[1]=1`, `H[17:16]==2'b11`: `{N[15:0],H[31:16]}`; needs count>=2.
- **`out_valid_o`:** the required count is met and `redirect_i` is low.
- **Consume:** occurs when `out_valid_o & out_ready_i`.
  - `pc_q` advances by 2 (compressed) or 4.
  - The head word pops except in the low-half compressed case.
- **Simultaneous push and consume:** count is unchanged when a pop occurs, otherwise +1.
- **Redirect:** `redirect_i` is honoured regardless of other inputs.
  - Pointers and count are cleared, and `pc_q <= {redirect_pc_i[31:1],1'b0}`.
  - Any word presented in that cycle is dropped.
  - No consume happens in that cycle.
- **Priority:** `rst_i` > `redirect_i` > push/consume.

## Timing
- **Reset values** (during and after `rst_i`): `out_valid_o=0`, `out_rdata_o=0` (storage cleared), `out_pc_o=BOOT_ADDR`, `out_compressed_o=0`, `in_ready_o=0` while `rst_i` is high, then 1.
- **Latency:** a word pushed in cycle N is visible on the outputs in cycle N+1. There is no input-to-output bypass.
- **Output paths:** all outputs are combinational from registered state, apart from the gating of `in_ready_o` and `out_valid_o` by `rst_i`/`redirect_i`.
- **Throughput:** one instruction per cycle while sufficient words are buffered.
- **Full buffer:** `in_ready_o=0`. A consume that pops in cycle N raises `in_ready_o` in cycle N+1.
- **Pointer wrap:** pointers wrap modulo DEPTH. N is the entry at `rd_ptr+1` mod DEPTH.
- **PC wrap:** `pc_q` wraps modulo 2^32.
- **Redirect timing:** the cycle after a redirect, `out_valid_o=0` and `out_pc_o` equals the new PC.

## Structure
- No new package contents are required. Reuse `ibex_pkg`; the compressed check is the `[1:0]!=2'b11` rule, kept local.
- One sub-module, `ibex_fetch_word_fifo`: a synchronous FIFO with flush, a peek of head and head+1, and a count output.
- The top level holds `pc_q`, the alignment mux and the pop logic.

## Test plan
- **Reset then single word:** push 0x00B50533.
  - Next cycle: `out_valid_o=1`, `out_rdata_o=0x00B50533`, `out_pc_o=0x80`, `out_compressed_o=0`.
- **Two compressed instructions in one word:** push 0x45014501 with `out_ready_i=1`.
  - Outputs 0x00004501 @0x80, then 0x00004501 @0x82; count returns to 0.
- **Straddling instruction:** push 0x05334501 only.
  - 0x4501 @0x80 is consumed, then `out_valid_o=0`.
  - Push 0x000000B5: the next cycle outputs 0x00B50533 @0x82, not compressed.
- **Full buffer:** DEPTH=4, `out_ready_i=0`, `in_valid_i` held with 5 words.
  - 4 words are accepted, then `in_ready_o=0` and the 5th is held.
  - One consume of a popping instruction gives `in_ready_o=1` the following cycle, and the 5th word is accepted.
- **Redirect mid-stream:** 3 words buffered, `in_valid_i=1`, redirect to 0x1003.
  - Next cycle: count=0, `out_valid_o=0`, `out_pc_o=0x1002`, and the concurrent word is dropped.
  - Push 0x45010000: output 0x4501 @0x1002.
- **Reset while full:** assert `rst_i` with 4 words buffered and valid output.
  - Next cycle: `out_valid_o=0`, `out_pc_o=0x80`, `out_rdata_o=0`, and `in_ready_o=1` after `rst_i` deasserts.
